bsg_down_io_rx: RTL
===================

// Module: bsg_down_io_rx
// PURPOSE
//  Receive front-end of the downstream channel. Registers the 8-bit off-chip byte stream, pairs bytes
//  into 16-bit words and writes them into the shared 2^ADDR_W x 16 channel buffer at wptr.
//  Publishes wptr/full to the core-side drain stage, which reads at rptr and assembles 32-bit words.
//  Returns flow-control credits to the remote sender as io_token_out pulses as the drain frees entries.
// PARAMETERS
//  ADDR_W       6  buffer address width; depth = 2^ADDR_W words; pointers are ADDR_W+1 bits
//  TOKEN_DECIM  4  words freed per io_token_out pulse (power of 2, 1..2^ADDR_W)
// PORTS
//  clk          in   1         clock
//  rst          in   1         reset, synchronous, active-high
//  io_valid_in  in   1         off-chip byte valid
//  io_data_in   in   8         off-chip byte
//  rptr         in   ADDR_W+1  drain-stage read pointer (wrap bit in MSB)
//  deq          in   1         drain stage consumed one word this cycle (rptr advances next edge)
//  buf_w_v      out  1         buffer write enable
//  buf_w_addr   out  ADDR_W    buffer write address (= wptr[ADDR_W-1:0])
//  buf_w_data   out  16        buffer write data
//  wptr         out  ADDR_W+1  write pointer
//  full         out  1         buffer full
//  io_token_out out  1         one-cycle credit pulse to remote sender
//  overflow     out  1         sticky: a word arrived while full and was dropped
// BEHAVIOUR
//  Reset (rst=1 at posedge): io_valid/io_data input regs=0, phase=0, byte_lo=0, wptr=0, full=0,
//   buf_w_v=0, buf_w_addr=0, buf_w_data=0, tok_cnt=0, io_token_out=0, overflow=0. Reset mid-word
//   discards the held low byte; no partial word is ever written.
//  Stage 1: io_valid <= io_valid_in; io_data <= io_data_in every cycle (1-cycle input register).
//  Stage 2 pairing, only when io_valid=1 (bubbles hold state, no timeout):
//   phase=0: byte_lo <= io_data; phase <= 1.
//   phase=1: word = {io_data, byte_lo} (first byte is bits[7:0]); phase <= 0; write attempt.
//  Write attempt: if !full -> buf_w_v=1, buf_w_addr=wptr[ADDR_W-1:0], buf_w_data=word (combinational
//   off registered state, sampled at the same edge); wptr <= wptr+1 (wraps mod 2^(ADDR_W+1)).
//   If full -> no write, wptr unchanged, overflow <= 1 (sticky until rst).
//  Latency: second byte on io_data_in at edge N -> buf_w_v high during cycle N+1 -> wptr updated at N+2.
//  full = (wptr[ADDR_W-1:0]==rptr[ADDR_W-1:0]) && (wptr[ADDR_W]!=rptr[ADDR_W]); combinational.
//   Empty (wptr==rptr) is the drain stage's concern; this block never reads rptr for anything else.
//  Simultaneous write and deq while full: full is evaluated on the current rptr, so the word is
//   dropped (overflow set). The sender's credits must prevent this; overflow flags protocol violation.
//  Credits: on deq=1, tok_cnt <= tok_cnt+1 (mod TOKEN_DECIM); when tok_cnt==TOKEN_DECIM-1 and deq=1,
//   io_token_out <= 1 for exactly one cycle, else io_token_out <= 0. Writes do not affect tokens.
//  Max sustained rate: one byte/cycle in, one word write per 2 cycles; back-to-back words need no gap.
//  All outputs registered except full and the buf_w_* combinational write port.
// TESTING
//  1. rst, then bytes 0x34,0x12 on consecutive cycles -> one write addr 0 data 0x1234; wptr=1; full=0.
//  2. Bytes 0xAA,bubble x3,0xBB -> single write data 0xBBAA; bubbles cause no phase change.
//  3. 128 bytes with rptr=0 -> 64 writes addr 0..63; wptr=0x40; full=1; 2 more bytes -> no write,
//     overflow=1, wptr stays 0x40.
//  4. Continue test 3: rptr=0x01 -> full=0; next pair writes addr 0, wptr=0x41; pointer wrap verified.
//  5. 8 deq pulses, TOKEN_DECIM=4 -> io_token_out pulses exactly twice, one cycle each, on the cycle
//     after the 4th and 8th deq.
//  6. Byte 0x55 then rst, then 0x66,0x77 -> write data 0x7766 (0x55 discarded); overflow=0.

Source files
------------

// File: rtl/bsg_down_io_rx.sv
// Downstream receive front-end: registers the off-chip byte stream, pairs bytes into 16-bit words,
// writes them into the channel buffer at wptr, and returns one credit per TOKEN_DECIM drained words.
`timescale 1ns/1ps

module bsg_down_io_rx #(
  parameter int ADDR_W      = 6,
  parameter int TOKEN_DECIM = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              io_valid_in,
  input  logic [7:0]        io_data_in,
  input  logic [ADDR_W:0]   rptr,
  input  logic              deq,
  output logic              buf_w_v,
  output logic [ADDR_W-1:0] buf_w_addr,
  output logic [15:0]       buf_w_data,
  output logic [ADDR_W:0]   wptr,
  output logic              full,
  output logic              io_token_out,
  output logic              overflow
);

  localparam int TOK_W = (TOKEN_DECIM > 1) ? $clog2(TOKEN_DECIM) : 1;
  localparam logic [TOK_W-1:0] TOK_LAST = TOK_W'(TOKEN_DECIM - 1);

  typedef enum logic {PH_LO = 1'b0, PH_HI = 1'b1} phase_e;

  phase_e            phase_q, phase_d;
  logic              io_valid_q, io_valid_d;
  logic [7:0]        io_data_q, io_data_d;
  logic [7:0]        byte_lo_q, byte_lo_d;
  logic [ADDR_W:0]   wptr_q, wptr_d;
  logic [TOK_W-1:0]  tok_cnt_q, tok_cnt_d;
  logic              io_token_out_q, io_token_out_d;
  logic              overflow_q, overflow_d;
  logic              word_done;

  // Pairing FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PH_LO;
    end else begin
      phase_q <= phase_d;
    end
  end

  // Pairing FSM: next state; bubbles leave the phase untouched
  always_comb begin
    phase_d = phase_q;
    if (io_valid_q) begin
      phase_d = (phase_q == PH_LO) ? PH_HI : PH_LO;
    end
  end

  // Pairing FSM: outputs (combinational write port off registered state)
  always_comb begin
    word_done  = io_valid_q && (phase_q == PH_HI);
    buf_w_v    = word_done && !full;
    buf_w_addr = wptr_q[ADDR_W-1:0];
    buf_w_data = {io_data_q, byte_lo_q};
  end

  // Full only compares against rptr as sampled now; a same-cycle deq does not rescue the word
  always_comb begin
    full = (wptr_q[ADDR_W-1:0] == rptr[ADDR_W-1:0]) && (wptr_q[ADDR_W] != rptr[ADDR_W]);
  end

  always_comb begin
    io_valid_d = io_valid_in;
    io_data_d  = io_data_in;
    byte_lo_d  = byte_lo_q;
    if (io_valid_q && (phase_q == PH_LO)) begin
      byte_lo_d = io_data_q;
    end
    wptr_d     = wptr_q + {{ADDR_W{1'b0}}, buf_w_v};
    overflow_d = overflow_q | (word_done & full);
  end

  always_comb begin
    tok_cnt_d      = tok_cnt_q;
    io_token_out_d = 1'b0;
    if (deq) begin
      tok_cnt_d      = (tok_cnt_q == TOK_LAST) ? '0 : tok_cnt_q + 1'b1;
      io_token_out_d = (tok_cnt_q == TOK_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      io_valid_q     <= 1'b0;
      io_data_q      <= '0;
      byte_lo_q      <= '0;
      wptr_q         <= '0;
      tok_cnt_q      <= '0;
      io_token_out_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      io_valid_q     <= io_valid_d;
      io_data_q      <= io_data_d;
      byte_lo_q      <= byte_lo_d;
      wptr_q         <= wptr_d;
      tok_cnt_q      <= tok_cnt_d;
      io_token_out_q <= io_token_out_d;
      overflow_q     <= overflow_d;
    end
  end

  assign wptr         = wptr_q;
  assign io_token_out = io_token_out_q;
  assign overflow     = overflow_q;

endmodule
